// File: rtl/anim_pkg.sv
// Shared encodings for the LED animation controller: FSM states, IR remote
// command bytes and pattern codes.
package anim_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } anim_state_t;

  localparam logic [7:0] IR_UP   = 8'h1B;
  localparam logic [7:0] IR_DOWN = 8'h1F;
  localparam logic [7:0] IR_PLAY = 8'h16;

  localparam logic [1:0] PAT_OFF = 2'd0;
  localparam logic [1:0] PAT_1   = 2'd1;
  localparam logic [1:0] PAT_2   = 2'd2;
  localparam logic [1:0] PAT_3   = 2'd3;

  // sw1 has the highest priority, sw3 the lowest
  function automatic logic [1:0] encode_pattern(input logic s1, input logic s2,
                                                input logic s3);
    logic [1:0] p;
    p = PAT_OFF;
    if (s1)      p = PAT_1;
    else if (s2) p = PAT_2;
    else if (s3) p = PAT_3;
    return p;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability-window
// debouncer and a one-cycle registered press event on the debounced 1->0 edge.
module btn_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  // Synchronizer idles at the released (high) level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level flips on the DB_CYCLES-th consecutive sample that differs from it;
  // any sample that agrees with the current level restarts the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level      <= 1'b1;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/anim_ctrl.sv
// LED animation sequencer: speed arbitration between buttons and IR remote,
// pattern selection from the mode switches, and the run/pause/stop step timer.
module anim_ctrl #(
  parameter int BASE_PERIOD = 5_000_000,
  parameter int SPEED_MAX   = 7,
  parameter int DB_CYCLES   = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       ir_valid,
  input  logic [7:0] ir_code,
  output logic       step,
  output logic       restart,
  output logic [1:0] pattern,
  output logic [3:0] speed,
  output logic [1:0] state
);

  import anim_pkg::*;

  localparam logic [3:0]  SPEED_TOP = 4'(SPEED_MAX);
  localparam logic [31:0] BASE      = 32'(BASE_PERIOD);

  logic        up_press;
  logic        down_press;
  logic [2:0]  sw_s1;
  logic [2:0]  sw_s2;
  logic [1:0]  enc;
  logic        ir_up;
  logic        ir_down;
  logic        ir_play;
  logic        up_req;
  logic        down_req;

  anim_state_t cur_state;
  anim_state_t state_next;
  logic [1:0]  pattern_q;
  logic [1:0]  pattern_next;
  logic        restart_q;
  logic        restart_next;
  logic        step_q;
  logic        step_next;
  logic [3:0]  speed_q;
  logic [31:0] cnt;
  logic [31:0] cnt_next;
  logic [31:0] shifted;
  logic [31:0] period_m1;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .btn   (up),
    .press (up_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .btn   (down),
    .press (down_press)
  );

  // Mode switches are level inputs, so they are only synchronized
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= {sw3, sw2, sw1};
      sw_s2 <= sw_s1;
    end
  end

  assign enc     = encode_pattern(sw_s2[0], sw_s2[1], sw_s2[2]);
  assign ir_up   = ir_valid && (ir_code == IR_UP);
  assign ir_down = ir_valid && (ir_code == IR_DOWN);
  assign ir_play = ir_valid && (ir_code == IR_PLAY);

  // Button and IR requests for the same direction merge into a single step
  assign up_req   = up_press | ir_up;
  assign down_req = down_press | ir_down;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= '0;
    end else if (up_req && !down_req && (speed_q != SPEED_TOP)) begin
      speed_q <= speed_q + 4'd1;
    end else if (down_req && !up_req && (speed_q != 4'd0)) begin
      speed_q <= speed_q - 4'd1;
    end
  end

  assign shifted   = BASE >> speed_q;
  assign period_m1 = (shifted > 32'd1) ? (shifted - 32'd1) : 32'd0;

  // Next-state, pattern and restart; a zero pattern overrides IR_PLAY
  always_comb begin
    state_next   = cur_state;
    pattern_next = pattern_q;
    restart_next = 1'b0;
    case (cur_state)
      STOP: begin
        if (enc != PAT_OFF) begin
          state_next   = RUN;
          pattern_next = enc;
          restart_next = 1'b1;
        end
      end
      RUN, PAUSE: begin
        if (enc == PAT_OFF) begin
          state_next   = STOP;
          pattern_next = PAT_OFF;
        end else begin
          if (enc != pattern_q) begin
            pattern_next = enc;
            restart_next = 1'b1;
          end
          if (ir_play) state_next = (cur_state == RUN) ? PAUSE : RUN;
        end
      end
      default: begin
        state_next   = STOP;
        pattern_next = PAT_OFF;
      end
    endcase
  end

  // Counter follows the state being entered, so step can only appear in RUN
  always_comb begin
    cnt_next  = cnt;
    step_next = 1'b0;
    if ((state_next == STOP) || restart_next) begin
      cnt_next = '0;
    end else if (state_next == RUN) begin
      if (cnt >= period_m1) begin
        step_next = 1'b1;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= STOP;
      pattern_q <= PAT_OFF;
      restart_q <= 1'b0;
      step_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      cur_state <= state_next;
      pattern_q <= pattern_next;
      restart_q <= restart_next;
      step_q    <= step_next;
      cnt       <= cnt_next;
    end
  end

  assign step    = step_q;
  assign restart = restart_q;
  assign pattern = pattern_q;
  assign speed   = speed_q;
  assign state   = cur_state;

endmodule

// File: tb/tb_anim_ctrl.sv
// Self-checking bench for anim_ctrl: table-driven IR command vectors plus
// directed sequences for debounce, arbitration, pause and reset corner cases.
module tb_anim_ctrl;

  logic       clk;
  logic       reset;
  logic       up;
  logic       down;
  logic       sw1;
  logic       sw2;
  logic       sw3;
  logic       ir_valid;
  logic [7:0] ir_code;
  logic       step;
  logic       restart;
  logic [1:0] pattern;
  logic [3:0] speed;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    int         exp_speed;
    int         exp_state;
  } ir_vec_t;

  ir_vec_t vecs [13];

  anim_ctrl #(
    .BASE_PERIOD (64),
    .SPEED_MAX   (7),
    .DB_CYCLES   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up       (up),
    .down     (down),
    .sw1      (sw1),
    .sw2      (sw2),
    .sw3      (sw3),
    .ir_valid (ir_valid),
    .ir_code  (ir_code),
    .step     (step),
    .restart  (restart),
    .pattern  (pattern),
    .speed    (speed),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int period_of(input int spd);
    int p;
    p = 64 >> spd;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle IR strobe; returns on the first sample after it was registered
  task automatic applyStimulus(input logic [7:0] code);
    ir_code  = code;
    ir_valid = 1'b1;
    @(negedge clk);
    ir_valid = 1'b0;
    ir_code  = 8'h00;
  endtask

  task automatic press_button(input bit is_up);
    if (is_up) up = 1'b0;
    else       down = 1'b0;
    tick(20);
    up   = 1'b1;
    down = 1'b1;
    tick(20);
  endtask

  // Counts running cycles (RUN, no restart) until step; -1 on timeout
  task automatic count_to_step(input int start, input int limit, output int total);
    int  n;
    bit  seen;
    n    = start;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (state == 2'd1 && !restart) n++;
      if (step) seen = 1'b1;
    end
    total = seen ? n : -1;
  endtask

  task automatic wait_step(input string name, input int limit);
    for (int i = 0; i < limit && !step; i++) @(negedge clk);
    if (!step) checkOutput(name, step, 1);
  endtask

  task automatic measure_gap(input string name, input int expected);
    int total;
    wait_step({name, " sync"}, 200);
    count_to_step(0, 200, total);
    checkOutput(name, total, expected);
  endtask

  initial begin
    int total;
    int n;
    int steps_seen;
    int not_paused;

    vecs[0]  = '{8'h1B, 1, 1};
    vecs[1]  = '{8'h1B, 2, 1};
    vecs[2]  = '{8'h1F, 1, 1};
    vecs[3]  = '{8'h00, 1, 1};
    vecs[4]  = '{8'h16, 1, 2};
    vecs[5]  = '{8'h1B, 2, 2};
    vecs[6]  = '{8'h1F, 1, 2};
    vecs[7]  = '{8'h16, 1, 1};
    vecs[8]  = '{8'h1F, 0, 1};
    vecs[9]  = '{8'h1F, 0, 1};
    vecs[10] = '{8'h1B, 1, 1};
    vecs[11] = '{8'h1B, 2, 1};
    vecs[12] = '{8'h1B, 3, 1};

    reset = 1'b0; up = 1'b1; down = 1'b1;
    sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0;
    ir_valid = 1'b0; ir_code = 8'h00;
    #2 reset = 1'b1;
    #1;
    checkOutput("reset step", step, 0);
    checkOutput("reset restart", restart, 0);
    checkOutput("reset pattern", pattern, 0);
    checkOutput("reset speed", speed, 0);
    checkOutput("reset state", state, 0);
    tick(3);
    reset = 1'b0;
    tick(2);

    $display("[TB] start from STOP with sw1");
    sw1 = 1'b1;
    tick(2);
    checkOutput("sw1 state before sync", state, 0);
    tick(1);
    checkOutput("sw1 state", state, 1);
    checkOutput("sw1 restart", restart, 1);
    checkOutput("sw1 pattern", pattern, 1);
    checkOutput("sw1 speed", speed, 0);
    count_to_step(0, 200, total);
    checkOutput("first step after entry", total, 64);
    measure_gap("gap speed 0", period_of(0));

    $display("[TB] button presses");
    repeat (5) press_button(1'b1);
    checkOutput("speed after 5 up", speed, 5);
    measure_gap("gap speed 5", period_of(5));
    repeat (4) press_button(1'b1);
    checkOutput("speed saturated at max", speed, 7);
    measure_gap("gap speed 7", period_of(7));
    repeat (8) press_button(1'b0);
    checkOutput("speed after 8 down", speed, 0);

    up = 1'b0;
    tick(3);
    up = 1'b1;
    tick(20);
    checkOutput("up glitch ignored", speed, 0);

    $display("[TB] pause and resume");
    wait_step("pause sync", 200);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (state == 2'd1 && !restart) n++;
    end
    applyStimulus(8'h16);
    checkOutput("play to pause", state, 2);
    steps_seen = 0;
    not_paused = 0;
    repeat (200) begin
      @(negedge clk);
      if (step) steps_seen++;
      if (state != 2'd2) not_paused++;
    end
    checkOutput("no step while paused", steps_seen, 0);
    checkOutput("pause held", not_paused, 0);
    applyStimulus(8'h16);
    checkOutput("play to run", state, 1);
    if (state == 2'd1 && !restart) n++;
    count_to_step(n, 200, total);
    checkOutput("resume completes period", total, 64);

    $display("[TB] IR command table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].code);
      checkOutput($sformatf("ir vec %0d speed", i), speed, vecs[i].exp_speed);
      checkOutput($sformatf("ir vec %0d state", i), state, vecs[i].exp_state);
    end

    $display("[TB] same-cycle arbitration");
    down = 1'b0;
    tick(7);
    applyStimulus(8'h1B);
    checkOutput("down plus ir_up", speed, 3);
    tick(12);
    down = 1'b1;
    tick(20);
    checkOutput("down plus ir_up settled", speed, 3);
    up = 1'b0;
    tick(7);
    applyStimulus(8'h1B);
    checkOutput("up plus ir_up", speed, 4);
    tick(12);
    up = 1'b1;
    tick(20);
    checkOutput("up plus ir_up settled", speed, 4);

    $display("[TB] pattern change in RUN");
    sw1 = 1'b0;
    sw2 = 1'b1;
    tick(2);
    checkOutput("pattern before sync", pattern, 1);
    tick(1);
    checkOutput("pattern change value", pattern, 2);
    checkOutput("pattern change restart", restart, 1);
    checkOutput("pattern change state", state, 1);
    tick(1);
    checkOutput("restart single cycle", restart, 0);
    n = (state == 2'd1 && !restart) ? 1 : 0;
    count_to_step(n, 100, total);
    checkOutput("count cleared on restart", total, period_of(4));

    $display("[TB] stop wins over play");
    sw2 = 1'b0;
    tick(2);
    applyStimulus(8'h16);
    checkOutput("stop wins state", state, 0);
    checkOutput("stop pattern", pattern, 0);
    checkOutput("stop step", step, 0);
    applyStimulus(8'h00);
    checkOutput("unknown code state", state, 0);
    checkOutput("unknown code speed", speed, 4);
    applyStimulus(8'h16);
    checkOutput("play ignored in stop", state, 0);

    $display("[TB] asynchronous reset mid-run");
    sw1 = 1'b1;
    tick(3);
    checkOutput("rerun state", state, 1);
    checkOutput("rerun speed kept", speed, 4);
    tick(5);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset step", step, 0);
    checkOutput("async reset restart", restart, 0);
    checkOutput("async reset pattern", pattern, 0);
    checkOutput("async reset speed", speed, 0);
    checkOutput("async reset state", state, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    checkOutput("post reset speed", speed, 0);
    checkOutput("post reset pattern", pattern, 0);
    tick(1);
    checkOutput("post reset rerun state", state, 1);
    checkOutput("post reset speed still 0", speed, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
